// File: rtl/readout_rx_meas_result_arbiter.sv
// Round-robin arbiter serialising per-channel measurement-result pulses onto one valid/ready stream.
// Optional capture timestamps are enabled with the READOUT_RX_ARB_TIMESTAMP_EN macro.
module readout_rx_meas_result_arbiter #(
  parameter int NUM_CH       = 8,
  parameter int CH_IDX_WIDTH = 3,
  parameter int TS_WIDTH     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       valid_meas_result_in,
  input  logic [NUM_CH-1:0]       meas_result_in,
  input  logic                    out_ready,
  input  logic                    clear_overflow_in,
  output logic                    out_valid,
  output logic [CH_IDX_WIDTH-1:0] out_ch_idx,
  output logic                    out_result,
`ifdef READOUT_RX_ARB_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]     out_timestamp,
`endif
  output logic [NUM_CH-1:0]       overflow_out,
  output logic                    busy_out
);

  if (((2 ** CH_IDX_WIDTH) < NUM_CH) || (TS_WIDTH < 1)) begin : g_bad_params
    $error("CH_IDX_WIDTH too narrow for NUM_CH or TS_WIDTH < 1");
  end

  logic [NUM_CH-1:0]       pending;
  logic [NUM_CH-1:0]       result_q;
  logic [NUM_CH-1:0]       grant_oh;
  logic [NUM_CH-1:0]       store_en;
  logic [NUM_CH-1:0]       ovf_set;
  logic [CH_IDX_WIDTH-1:0] last_grant;
  logic [CH_IDX_WIDTH-1:0] grant_idx;
  logic [CH_IDX_WIDTH-1:0] cand;
  logic                    found;
  logic                    slot_free;
  logic                    grant;

`ifdef READOUT_RX_ARB_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_q [NUM_CH];
`endif

  // Search begins one past the last winner, so every pending channel is served within NUM_CH grants.
  always_comb begin
    slot_free = !out_valid || out_ready;
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_IDX_WIDTH'((int'(last_grant) + k) % NUM_CH);
      if (!found && pending[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant    = slot_free && found;
    grant_oh = grant ? (NUM_CH'(1) << grant_idx) : '0;
    // A channel whose slot is emptied by this grant can take a new pulse without overflowing.
    store_en = valid_meas_result_in & ~(pending & ~grant_oh);
    ovf_set  = valid_meas_result_in & pending & ~grant_oh;
  end

  assign busy_out = (|pending) || out_valid;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (store_en[i]) begin
        result_q[i] <= meas_result_in[i];
`ifdef READOUT_RX_ARB_TIMESTAMP_EN
        ts_q[i] <= ts_cnt;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      last_grant   <= CH_IDX_WIDTH'(NUM_CH - 1);
      out_valid    <= 1'b0;
      out_ch_idx   <= '0;
      out_result   <= 1'b0;
      overflow_out <= '0;
`ifdef READOUT_RX_ARB_TIMESTAMP_EN
      ts_cnt        <= '0;
      out_timestamp <= '0;
`endif
    end else begin
      pending      <= (pending & ~grant_oh) | valid_meas_result_in;
      overflow_out <= (clear_overflow_in ? '0 : overflow_out) | ovf_set;
`ifdef READOUT_RX_ARB_TIMESTAMP_EN
      ts_cnt <= ts_cnt + 1'b1;
`endif
      if (slot_free) begin
        out_valid <= grant;
        if (grant) begin
          last_grant <= grant_idx;
          out_ch_idx <= grant_idx;
          out_result <= result_q[grant_idx];
`ifdef READOUT_RX_ARB_TIMESTAMP_EN
          out_timestamp <= ts_q[grant_idx];
`endif
        end
      end
    end
  end

endmodule
